// File: rtl/spi_expander_master_pkg.sv
// Shared definitions for the serial I/O expander initiator and its bench model.
// Provides the frame FSM state type and the default sclk/CE timing constants.
package spi_expander_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GUARD,
    DONE
  } state_t;

  localparam int unsigned DEF_HALF      = 2;
  localparam int unsigned DEF_SETUP_CYC = 4;
  localparam int unsigned DEF_GUARD_CYC = 4;

  // Phase timer width; covers any phase length up to 256 clk cycles.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/spi_expander_master_timer.sv
// spi_phase_timer: loadable down-counter timing one FSM phase.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : load value into the counter on this edge
//   value      : phase length minus one
//   tc         : high during the last cycle of the phase (count is zero)
module spi_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb tc = (cnt == '0);

endmodule

// File: rtl/spi_expander_master.sv
// spi_expander_master: SPI initiator for the serial I/O expander.
// Each frame shifts OUTBITS bits out on mosi (MSB first) and reads INBITS bits
// from miso (LSB first) under an active-low CE, then reports via done.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : frame request, sampled only in IDLE
//   wdata      : output pattern, captured when start is accepted
//   busy, done : frame in progress / one-cycle completion pulse
//   rdata      : bits read in the last frame, updated with done
//   sclk, ce   : SPI clock (idle low) and chip enable (active low)
//   mosi, miso : serial data to / from the expander
module spi_expander_master
  import spi_expander_master_pkg::*;
#(
  parameter int unsigned OUTBITS   = 7,
  parameter int unsigned INBITS    = 3,
  parameter int unsigned HALF      = DEF_HALF,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OUTBITS-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic [INBITS-1:0]  rdata,
  output logic               sclk,
  output logic               ce,
  output logic               mosi,
  input  logic               miso
);

  localparam int unsigned KW = $clog2(OUTBITS + 1);

  state_t             state;
  logic [OUTBITS-1:0] sr;
  logic [KW-1:0]      k;
  logic [INBITS-1:0]  rbuf;
  logic               mosi_pend;

  logic               t_load;
  logic [CNT_W-1:0]   t_val;
  logic               t_tc;

  spi_phase_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .value (t_val),
    .tc    (t_tc)
  );

  // The timer is reloaded on every edge that moves to a new phase, so each
  // phase lasts exactly its programmed length.
  always_comb begin
    t_load = 1'b0;
    t_val  = CNT_W'(HALF - 1);
    unique case (state)
      IDLE: begin
        t_load = start;
        t_val  = CNT_W'(SETUP_CYC - 1);
      end
      SETUP, LOW, HIGH: t_load = t_tc;
      HOLD: begin
        t_load = t_tc;
        t_val  = CNT_W'(GUARD_CYC - 1);
      end
      default: t_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      k         <= '0;
      rbuf      <= '0;
      mosi_pend <= 1'b0;
      ce        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= wdata;
            k     <= '0;
            ce    <= 1'b0;
            mosi  <= wdata[OUTBITS-1];
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (t_tc) state <= LOW;
        end
        LOW: begin
          // mosi moves one edge after the falling sclk edge, never on it.
          if (mosi_pend) begin
            mosi      <= sr[OUTBITS-1];
            mosi_pend <= 1'b0;
          end
          if (t_tc) begin
            for (int unsigned i = 0; i < INBITS; i++) begin
              if (k == KW'(i)) rbuf[i] <= miso;
            end
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (t_tc) begin
            sclk <= 1'b0;
            sr   <= {sr[OUTBITS-2:0], 1'b0};
            k    <= k + KW'(1);
            if (k == KW'(OUTBITS - 1)) begin
              state <= HOLD;
            end else begin
              mosi_pend <= 1'b1;
              state     <= LOW;
            end
          end
        end
        HOLD: begin
          if (t_tc) begin
            ce    <= 1'b1;
            state <= GUARD;
          end
        end
        GUARD: begin
          if (t_tc) begin
            rdata <= rbuf;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_expander_master.sv
// Bench for spi_expander_master: two configurations (default timing and
// HALF=3/SETUP_CYC=5), each with a behavioural expander and a frame-level
// model of every output in every cycle.
module tb_spi_expander_master;

  localparam int unsigned N = 7;
  localparam int unsigned I = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : cfg
    localparam int unsigned H  = (gi == 0) ? 2 : 3;
    localparam int unsigned S  = (gi == 0) ? 4 : 5;
    localparam int unsigned G  = 4;
    // Index of the done cycle, counted from the first cycle after acceptance.
    localparam int DP = S + 2 * H * N + H + G;
    // Cycles from the start-accept cycle through the done cycle, inclusive.
    localparam int LAT_LIT   = (gi == 0) ? (1 + 4 + 28 + 2 + 4 + 1) : (1 + 5 + 42 + 3 + 4 + 1);
    localparam int CELOW_LIT = (gi == 0) ? (4 + 28 + 2) : (5 + 42 + 3);

    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] wdata = '0;
    logic         busy, done, sclk, ce, mosi;
    logic [I-1:0] rdata;
    logic         miso = 1'b0;
    logic         fin  = 1'b0;

    spi_expander_master #(
      .OUTBITS   (N),
      .INBITS    (I),
      .HALF      (H),
      .SETUP_CYC (S),
      .GUARD_CYC (G)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata),
      .sclk  (sclk),
      .ce    (ce),
      .mosi  (mosi),
      .miso  (miso)
    );

    // Expander: loads inputs on CE fall, advances sout on sclk rise,
    // captures sin on sclk fall, latches outputs on CE rise.
    logic [I-1:0] inputs = '0;
    logic [I-1:0] sreg   = '0;
    logic [N-1:0] shin   = '0;
    logic [N-1:0] outs   = '0;

    always @(negedge ce) begin
      sreg = inputs;
      miso = sreg[0];
    end
    always @(posedge sclk) if (!ce) begin
      sreg = sreg >> 1;
      miso = sreg[0];
    end
    always @(negedge sclk) if (!ce) shin = {shin[N-2:0], mosi};
    always @(posedge ce) outs = shin;

    // Frame model: p is the cycle index inside the current frame, -1 when idle.
    int           p = -1;
    logic [N-1:0] wf = '0;
    logic [I-1:0] inf = '0;
    logic         last_mosi = 1'b0;
    logic [I-1:0] rd_exp = '0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        p = -1;
        last_mosi = 1'b0;
        rd_exp = '0;
      end else if (p < 0) begin
        if (start) begin
          p   = 0;
          wf  = wdata;
          inf = inputs;
        end
      end else if (p == DP) begin
        p = -1;
        rd_exp = inf;
        last_mosi = wf[0];
      end else begin
        p++;
      end
    end

    int   lat = 0, celow = 0, rises = 0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin : cmp
      logic e_ce, e_sclk, e_mosi, e_busy, e_done;
      logic [I-1:0] e_rd;
      int q, kk, r;
      e_ce = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rd = '0;
      if (reset) begin
        e_mosi = 1'b0;
      end else if (p < 0) begin
        e_mosi = last_mosi;
        e_rd   = rd_exp;
      end else begin
        e_ce = 1'b0; e_busy = 1'b1; e_mosi = wf[0]; e_rd = rd_exp;
        q = p - S;
        if (p < S) begin
          e_mosi = wf[N-1];
        end else if (q < 2 * H * N) begin
          kk = q / (2 * H);
          r  = q % (2 * H);
          e_sclk = (r >= H);
          e_mosi = (kk > 0 && r == 0) ? wf[N-kk] : wf[N-1-kk];
        end else if (q >= 2 * H * N + H) begin
          e_ce = 1'b1;
          if (p == DP) begin
            e_busy = 1'b0;
            e_done = 1'b1;
            e_rd   = inf;
          end
        end
      end
      chk($sformatf("c%0d ce p=%0d", gi, p), ce, e_ce);
      chk($sformatf("c%0d sclk p=%0d", gi, p), sclk, e_sclk);
      chk($sformatf("c%0d mosi p=%0d", gi, p), mosi, e_mosi);
      chk($sformatf("c%0d busy p=%0d", gi, p), busy, e_busy);
      chk($sformatf("c%0d done p=%0d", gi, p), done, e_done);
      chk($sformatf("c%0d rdata p=%0d", gi, p), rdata, e_rd);

      if (!reset && p == 0) begin
        lat = 1; celow = 0; rises = 0;
      end
      lat++;
      if (ce === 1'b0) celow++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = sclk;
      if (done === 1'b1) begin
        chk($sformatf("c%0d latency", gi), lat, LAT_LIT);
        chk($sformatf("c%0d ce_low_cycles", gi), celow, CELOW_LIT);
        chk($sformatf("c%0d sclk_rises", gi), rises, 7);
      end
    end

    task automatic wait_done(input bit rnd);
      int c;
      c = 0;
      while (done !== 1'b1 && c < 400) begin
        if (rnd) start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        c++;
      end
      chk($sformatf("c%0d done_timeout", gi), (c < 400), 1);
    endtask

    // Called and returns in an idle cycle.
    task automatic frame(input logic [N-1:0] w, input logic [I-1:0] in, input bit rnd);
      inputs = in;
      wdata  = w;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wdata = N'($urandom);
      wait_done(rnd);
      start = 1'b0;
      chk($sformatf("c%0d rdata_w%0h", gi, w), rdata, in);
      chk($sformatf("c%0d exp_outputs_w%0h", gi, w), outs, w);
      @(posedge clk); #1;
    endtask

    initial begin : stim
      int c;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("c%0d rst_ce", gi), ce, 1);
      chk($sformatf("c%0d rst_sclk", gi), sclk, 0);
      chk($sformatf("c%0d rst_mosi", gi), mosi, 0);
      chk($sformatf("c%0d rst_busy", gi), busy, 0);
      chk($sformatf("c%0d rst_done", gi), done, 0);
      chk($sformatf("c%0d rst_rdata", gi), rdata, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      frame(7'h55, 3'b101, 1'b0);
      chk($sformatf("c%0d loop_rdata", gi), rdata, 3'b101);
      chk($sformatf("c%0d loop_out", gi), outs, 7'h55);
      frame(7'h7F, 3'b000, 1'b0);
      chk($sformatf("c%0d pulse_out", gi), outs, 7'h7F);
      frame(7'h33, 3'b100, 1'b0);
      chk($sformatf("c%0d sweep_rdata", gi), rdata, 3'b100);

      // start held high: frames run strictly one after another
      inputs = 3'b010;
      wdata  = 7'h01;
      start  = 1'b1;
      @(posedge clk); #1;
      wait_done(1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      wait_done(1'b0);
      start = 1'b0;
      chk($sformatf("c%0d hold_out", gi), outs, 7'h01);
      @(posedge clk); #1;

      // back-to-back: second start in the idle cycle right after done
      frame(7'h12, 3'b011, 1'b0);
      chk($sformatf("c%0d b2b_rd1", gi), rdata, 3'b011);
      frame(7'h6D, 3'b110, 1'b0);
      chk($sformatf("c%0d b2b_rd2", gi), rdata, 3'b110);
      chk($sformatf("c%0d b2b_out", gi), outs, 7'h6D);

      // reset during the 4th HIGH phase
      inputs = 3'b111;
      wdata  = 7'h4C;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (p != int'(S + 7 * H) && c < 400) begin
        @(posedge clk); #1;
        c++;
      end
      chk($sformatf("c%0d reach_high4", gi), (c < 400), 1);
      chk($sformatf("c%0d pre_rst_sclk", gi), sclk, 1);
      reset = 1'b1;
      #1;
      chk($sformatf("c%0d mid_rst_ce", gi), ce, 1);
      chk($sformatf("c%0d mid_rst_sclk", gi), sclk, 0);
      chk($sformatf("c%0d mid_rst_mosi", gi), mosi, 0);
      chk($sformatf("c%0d mid_rst_busy", gi), busy, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      frame(7'h2A, 3'b001, 1'b0);
      chk($sformatf("c%0d post_rst_out", gi), outs, 7'h2A);

      for (int unsigned n = 0; n < 8; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        frame(N'($urandom), I'($urandom), 1'b1);
      end
      fin = 1'b1;
    end
  end

  initial begin : top
    int c;
    c = 0;
    while (!(cfg[0].fin && cfg[1].fin) && c < 50000) begin
      @(posedge clk);
      c++;
    end
    chk("global_timeout", (c < 50000), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
